// File: rtl/spi_avalon_master_bridge.sv
// SPI slave (mode 0, MSB first) to Avalon-MM master bridge, oversampled in the MCLK domain.
// Define BRIDGE_TIMEOUT_EN to add the waitrequest timeout with sticky error status.
module spi_avalon_master_bridge #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              rsi_MRST_reset,
    input  logic              csi_MCLK_clk,
    input  logic              coe_spi_sck,
    input  logic              coe_spi_cs_n,
    input  logic              coe_spi_mosi,
    output logic              coe_spi_miso,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic [31:0]       avm_m0_writedata,
    input  logic [31:0]       avm_m0_readdata,
    output logic [3:0]        avm_m0_byteenable,
    output logic              avm_m0_write,
    output logic              avm_m0_read,
    input  logic              avm_m0_waitrequest
);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StWdata, StRdReq, StWrReq, StDone
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev, cs_prev;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall;

    logic [5:0]        bit_cnt_q;
    logic [30:0]       rx_sr_q;
    logic              cmd_wr_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              rd_valid_q;
    logic              miso_q;
    logic [4:0]        rd_idx;
    logic              frame_rx;
    logic              rd_done;
    logic              timeout;
    logic              err;

    // cs_n synchronizer resets high so reset release never looks like a frame start
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], coe_spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], coe_spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], coe_spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    assign frame_rx = (state_q == StCmd) || (state_q == StAddr) || (state_q == StWdata);
    assign rd_done  = (state_q == StRdReq) && (!avm_m0_waitrequest || timeout);
    // Frame bit 24 carries readdata[31], bit 55 carries readdata[0]
    assign rd_idx   = 5'd23 - bit_cnt_q[4:0];

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StCmd;
            StCmd: begin
                if (cs_s) state_d = StIdle;
                else if (sck_rise && bit_cnt_q == 6'd7) state_d = StAddr;
            end
            StAddr: begin
                if (cs_s) state_d = StIdle;
                else if (sck_rise && bit_cnt_q == 6'd23) state_d = cmd_wr_q ? StWdata : StRdReq;
            end
            StWdata: begin
                if (cs_s) state_d = StIdle;
                else if (sck_rise && bit_cnt_q == 6'd55) begin
                    state_d = (be_q == 4'b0000) ? StDone : StWrReq;
                end
            end
            StRdReq, StWrReq: if (!avm_m0_waitrequest || timeout) state_d = StDone;
            StDone:  if (cs_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        avm_m0_read  = (state_q == StRdReq);
        avm_m0_write = (state_q == StWrReq);
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            cmd_wr_q   <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            if (sck_rise && state_q != StIdle && bit_cnt_q < 6'd56) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            if (sck_rise && frame_rx) begin
                rx_sr_q <= {rx_sr_q[29:0], mosi_s};
                if (state_q == StCmd && bit_cnt_q == 6'd7) begin
                    cmd_wr_q <= rx_sr_q[6];
                    be_q     <= {rx_sr_q[2:0], mosi_s};
                end
                if (state_q == StAddr && bit_cnt_q == 6'd23) begin
                    addr_q <= ADDR_W'({rx_sr_q[14:0], mosi_s});
                end
                if (state_q == StWdata && bit_cnt_q == 6'd55) begin
                    wdata_q <= {rx_sr_q, mosi_s};
                end
            end
            if (rd_done) begin
                rdata_q <= timeout ? 32'hDEAD_BEEF : avm_m0_readdata;
                // Data only reaches MISO if it arrives before byte 3 has ended
                if (bit_cnt_q < 6'd32) rd_valid_q <= 1'b1;
            end
            if (state_q == StIdle) begin
                miso_q <= 1'b0;
            end else if (sck_fall) begin
                if (bit_cnt_q == 6'd7) begin
                    miso_q <= err;
                end else if (bit_cnt_q >= 6'd24 && bit_cnt_q < 6'd56) begin
                    miso_q <= rd_valid_q & rdata_q[rd_idx];
                end else begin
                    miso_q <= 1'b0;
                end
            end
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic [ToW-1:0] to_cnt_q;
    logic           err_q;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((avm_m0_read || avm_m0_write) && avm_m0_waitrequest && !timeout) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
            // Sticky until the status bit has been clocked out to the MCU
            if (timeout) begin
                err_q <= 1'b1;
            end else if (state_q == StCmd && sck_rise && bit_cnt_q == 6'd7) begin
                err_q <= 1'b0;
            end
        end
    end

    assign timeout = (avm_m0_read || avm_m0_write) && avm_m0_waitrequest &&
                     (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
    assign err     = err_q;
`else
    // Requests wait indefinitely for waitrequest to drop
    assign timeout = (TIMEOUT_CYC == 0) && 1'b0;
    assign err     = 1'b0;
`endif

    assign coe_spi_miso      = miso_q;
    assign avm_m0_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign avm_m0_writedata  = wdata_q;
    assign avm_m0_byteenable = be_q;

endmodule

// File: tb/tb_spi_avalon_master_bridge.sv
// Directed bench for spi_avalon_master_bridge: SPI frames in, Avalon slave model out.
// Define BRIDGE_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYC=16).
module tb_spi_avalon_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'h0;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic        waitreq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_avalon_master_bridge #(
        .ADDR_W      (16),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .rsi_MRST_reset     (rst),
        .csi_MCLK_clk       (clk),
        .coe_spi_sck        (sck),
        .coe_spi_cs_n       (cs_n),
        .coe_spi_mosi       (mosi),
        .coe_spi_miso       (miso),
        .avm_m0_address     (address),
        .avm_m0_writedata   (writedata),
        .avm_m0_readdata    (readdata),
        .avm_m0_byteenable  (byteenable),
        .avm_m0_write       (write),
        .avm_m0_read        (read),
        .avm_m0_waitrequest (waitreq)
    );

    // Slave model: stall each request for wait_n cycles, or forever while stuck
    int   wait_n = 0;
    logic stuck = 1'b0;
    int   req_age = 0;
    always @(posedge clk) req_age <= (read || write) ? req_age + 1 : 0;
    assign waitreq = stuck || (req_age < wait_n);

    int          wr_hi = 0, rd_hi = 0, wr_acc = 0, rd_acc = 0, unstable = 0;
    logic        prev_req = 1'b0;
    logic [51:0] prev_bus = '0;
    logic [15:0] acc_addr = '0;
    logic [31:0] acc_wdata = '0;
    logic [3:0]  acc_be = '0;

    always @(negedge clk) begin
        if (write) wr_hi <= wr_hi + 1;
        if (read) rd_hi <= rd_hi + 1;
        if ((write || read) && !waitreq) begin
            if (write) wr_acc <= wr_acc + 1;
            if (read) rd_acc <= rd_acc + 1;
            acc_addr  <= address;
            acc_wdata <= writedata;
            acc_be    <= byteenable;
        end
        if ((write || read) && prev_req && {address, writedata, byteenable} !== prev_bus) begin
            unstable <= unstable + 1;
        end
        prev_req <= write || read;
        prev_bus <= {address, writedata, byteenable};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MOSI changes half a period before each rise; MISO is sampled just before the rise
    task automatic spi_frame(input logic [55:0] tx, input int nbytes, input int half,
                             output logic [55:0] rx);
        rx = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbytes * 8; i++) begin
            mosi = tx[55-i];
            repeat (half) @(negedge clk);
            rx[55-i] = miso;
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
        repeat (12) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    logic [55:0] rx;
    int w0, r0, wa0, ra0, u0;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_write", write, 1'b0);
        chk("reset_read", read, 1'b0);
        chk("reset_miso", miso, 1'b0);
        chk("reset_addr", address, 16'h0);

        // Reset while a write is stalled (held after CS_n rise)
        stuck = 1'b1;
        wa0 = wr_acc;
        spi_frame(56'h81_0040_01020304, 7, 8, rx);
        chk("t1_write_held", write, 1'b1);
        chk("t1_addr_held", address, 16'h0040);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_write", write, 1'b0);
        chk("t1_rst_read", read, 1'b0);
        chk("t1_rst_miso", miso, 1'b0);
        chk("t1_rst_be", byteenable, 4'h0);
        chk("t1_rst_wdata", writedata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_no_accept", wr_acc - wa0, 0);

        // Single-cycle write
        w0 = wr_hi; wa0 = wr_acc; r0 = rd_hi;
        spi_frame(56'h8F_0004_12345678, 7, 8, rx);
        chk("t2_wr_cycles", wr_hi - w0, 1);
        chk("t2_wr_accepts", wr_acc - wa0, 1);
        chk("t2_no_read", rd_hi - r0, 0);
        chk("t2_addr", acc_addr, 16'h0004);
        chk("t2_wdata", acc_wdata, 32'h12345678);
        chk("t2_be", acc_be, 4'hF);
        chk("t2_status", rx[55:48], 8'h00);

        // Write stalled five cycles
        wait_n = 5;
        w0 = wr_hi; wa0 = wr_acc; u0 = unstable;
        spi_frame(56'h83_0010_AABBCCDD, 7, 8, rx);
        wait_n = 0;
        chk("t3_wr_cycles", wr_hi - w0, 6);
        chk("t3_wr_accepts", wr_acc - wa0, 1);
        chk("t3_stable", unstable - u0, 0);
        chk("t3_addr", acc_addr, 16'h0010);
        chk("t3_wdata", acc_wdata, 32'hAABBCCDD);
        chk("t3_be", acc_be, 4'h3);

        // Read
        readdata = 32'hCAFEF00D;
        r0 = rd_hi; ra0 = rd_acc; w0 = wr_hi;
        spi_frame(56'h0F_0008_00000000, 7, 8, rx);
        chk("t4_rd_cycles", rd_hi - r0, 1);
        chk("t4_rd_accepts", rd_acc - ra0, 1);
        chk("t4_no_write", wr_hi - w0, 0);
        chk("t4_addr", acc_addr, 16'h0008);
        chk("t4_be", acc_be, 4'hF);
        chk("t4_status", rx[55:48], 8'h00);
        chk("t4_addr_bytes", rx[47:32], 16'h0000);
        chk("t4_miso_data", rx[31:0], 32'hCAFEF00D);

        // Aborted write frame, then a read
        r0 = rd_hi; w0 = wr_hi;
        spi_frame(56'h8F_0020_55555555, 2, 8, rx);
        chk("t5_abort_write", wr_hi - w0, 0);
        chk("t5_abort_read", rd_hi - r0, 0);
        readdata = 32'h11223344;
        r0 = rd_hi; ra0 = rd_acc;
        spi_frame(56'h05_000C_00000000, 7, 8, rx);
        chk("t5_rd_accepts", rd_acc - ra0, 1);
        chk("t5_addr", acc_addr, 16'h000C);
        chk("t5_be", acc_be, 4'h5);
        chk("t5_miso_data", rx[31:0], 32'h11223344);

        // Write with no byte lanes: no bus cycle
        w0 = wr_hi;
        spi_frame(56'h80_0014_99999999, 7, 8, rx);
        chk("be0_no_write", wr_hi - w0, 0);
        chk("be0_status", rx[55:48], 8'h00);

`ifdef BRIDGE_TIMEOUT_EN
        // Stuck read times out; slower SCK so the substituted data lands in byte 3
        stuck = 1'b1;
        r0 = rd_hi;
        spi_frame(56'h0F_0030_00000000, 7, 32, rx);
        stuck = 1'b0;
        chk("t6_rd_cycles", rd_hi - r0, 16);
        chk("t6_read_low", read, 1'b0);
        chk("t6_miso_data", rx[31:0], 32'hDEADBEEF);
        w0 = wr_hi;
        spi_frame(56'h80_0000_00000000, 7, 8, rx);
        chk("t6_status_err", rx[55:48], 8'h01);
        chk("t6_no_write", wr_hi - w0, 0);
        spi_frame(56'h80_0000_00000000, 7, 8, rx);
        chk("t6_status_clr", rx[55:48], 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
